// File: rtl/uart_rx.sv
// uart_rx: asynchronous serial receiver with 16x oversampling and a
// first-word-fall-through receive FIFO.
// Frame is 8N1 by default; defining UART_RX_PARITY_EN selects 8E1 and adds
// the PARITY state and the even-parity check that drives parity_err.
//
// state      | meaning
// -----------+----------------------------------------------------------
// IDLE       | line idle, waiting for a falling edge on rxd_s
// START      | qualifying the start bit at its midpoint (8th tick)
// DATA       | sampling 8 data bits LSB first, every 16th tick
// PARITY     | sampling the even-parity bit (UART_RX_PARITY_EN only)
// STOP       | sampling the stop bit at its midpoint
// WAIT_HIGH  | bad stop bit seen, waiting for the line to return high
module uart_rx #(
   parameter int BAUD_RATE  = 57_600,
   parameter int CLOCK_RATE = 50_000_000,
   parameter int FIFO_DEPTH = 16
) (
   input  logic       clk_rx,
   input  logic       rst_clk_rx_n,
   input  logic       rxd_i,
   input  logic       rd_en,
   output logic [7:0] rx_dout,
   output logic       rx_fifo_empty,
   output logic       frame_err,
   output logic       parity_err,
   output logic       overrun_err,
   output logic       rx_store_qual,
   output logic [1:0] rx_frame_indicator,
   output logic       rx_bit_indicator
);

   localparam int DIV = (CLOCK_RATE + 8 * BAUD_RATE) / (16 * BAUD_RATE);
   localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int AW  = $clog2(FIFO_DEPTH);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
`ifdef UART_RX_PARITY_EN
      ST_PARITY,
`endif
      ST_STOP,
      ST_WAIT_HIGH
   } state_t;

   state_t        state, state_nxt;
   logic [DW-1:0] baud_cnt;
   logic          baud_x16_en;
   logic          rxd_meta, rxd_s;
   logic [3:0]    os_cnt;
   logic          os_tc;
   logic [2:0]    bit_cnt;
   logic [7:0]    shift_reg;
   logic          bit_smp;
   logic [1:0]    frame_ind;
   logic          stop_smp;
   logic          par_bad;
   logic          wr_req;
   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW:0]   wr_ptr, rd_ptr;
   logic          fifo_full, do_wr, do_rd;

   // Baud tick: down-counter reloads at terminal count, one pulse every DIV clocks
   always_ff @(posedge clk_rx or negedge rst_clk_rx_n) begin
      if (!rst_clk_rx_n)      baud_cnt <= DW'(DIV - 1);
      else if (baud_cnt == '0) baud_cnt <= DW'(DIV - 1);
      else                    baud_cnt <= baud_cnt - 1'b1;
   end

   assign baud_x16_en = (baud_cnt == '0);

   // Two-flop synchroniser, resets to the idle (high) line level
   always_ff @(posedge clk_rx or negedge rst_clk_rx_n) begin
      if (!rst_clk_rx_n) {rxd_s, rxd_meta} <= 2'b11;
      else               {rxd_s, rxd_meta} <= {rxd_meta, rxd_i};
   end

   assign os_tc = baud_x16_en && (os_cnt == 4'd15);

   // State register
   always_ff @(posedge clk_rx or negedge rst_clk_rx_n) begin
      if (!rst_clk_rx_n) state <= ST_IDLE;
      else               state <= state_nxt;
   end

   // Next-state decode plus bit-sample strobe and frame indicator
   always_comb begin
      state_nxt = state;
      bit_smp   = 1'b0;
      frame_ind = 2'b00;
      case (state)
         ST_IDLE: begin
            if (!rxd_s) state_nxt = ST_START;
         end
         ST_START: begin
            frame_ind = 2'b01;
            if (baud_x16_en && (os_cnt == 4'd7)) state_nxt = rxd_s ? ST_IDLE : ST_DATA;
         end
         ST_DATA: begin
            frame_ind = 2'b10;
            if (os_tc) begin
               bit_smp = 1'b1;
               if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                  state_nxt = ST_PARITY;
`else
                  state_nxt = ST_STOP;
`endif
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         ST_PARITY: begin
            frame_ind = 2'b11;
            if (os_tc) begin
               bit_smp   = 1'b1;
               state_nxt = ST_STOP;
            end
         end
`endif
         ST_STOP: begin
            frame_ind = 2'b11;
            if (os_tc) begin
               bit_smp   = 1'b1;
               state_nxt = rxd_s ? ST_IDLE : ST_WAIT_HIGH;
            end
         end
         ST_WAIT_HIGH: begin
            if (rxd_s) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Oversample counter restarts on every state change so each phase is timed from its entry
   always_ff @(posedge clk_rx or negedge rst_clk_rx_n) begin
      if (!rst_clk_rx_n)          os_cnt <= 4'd0;
      else if (state_nxt != state) os_cnt <= 4'd0;
      else if (baud_x16_en)       os_cnt <= os_cnt + 4'd1;
   end

   // Data bit counter and LSB-first shift register
   always_ff @(posedge clk_rx or negedge rst_clk_rx_n) begin
      if (!rst_clk_rx_n) begin
         bit_cnt   <= 3'd0;
         shift_reg <= 8'h00;
      end else if (state != ST_DATA) begin
         bit_cnt   <= 3'd0;
      end else if (bit_smp) begin
         bit_cnt   <= bit_cnt + 3'd1;
         shift_reg <= {rxd_s, shift_reg[7:1]};
      end
   end

`ifdef UART_RX_PARITY_EN
   logic par_bit;

   // Captured parity bit, checked against the data at the stop-bit sample
   always_ff @(posedge clk_rx or negedge rst_clk_rx_n) begin
      if (!rst_clk_rx_n)                     par_bit <= 1'b0;
      else if (bit_smp && state == ST_PARITY) par_bit <= rxd_s;
   end

   assign par_bad = (^shift_reg) ^ par_bit;
`else
   assign par_bad = 1'b0;
`endif

   assign stop_smp = bit_smp && (state == ST_STOP);

   // Frame verdict: write request and error pulses, one cycle after the stop sample
   always_ff @(posedge clk_rx or negedge rst_clk_rx_n) begin
      if (!rst_clk_rx_n) begin
         wr_req      <= 1'b0;
         frame_err   <= 1'b0;
         overrun_err <= 1'b0;
      end else begin
         wr_req      <= stop_smp && rxd_s && !par_bad;
         frame_err   <= stop_smp && !rxd_s;
         overrun_err <= wr_req && fifo_full && !rd_en;
      end
   end

`ifdef UART_RX_PARITY_EN
   logic par_err_q;

   // Parity error pulse aligned with frame_err
   always_ff @(posedge clk_rx or negedge rst_clk_rx_n) begin
      if (!rst_clk_rx_n) par_err_q <= 1'b0;
      else               par_err_q <= stop_smp && par_bad;
   end

   assign parity_err = par_err_q;
`else
   assign parity_err = 1'b0;
`endif

   assign rx_fifo_empty = (wr_ptr == rd_ptr);
   assign fifo_full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_rd         = rd_en && !rx_fifo_empty;
   assign do_wr         = wr_req && (!fifo_full || rd_en);

   // FIFO pointers; extra MSB separates full from empty
   always_ff @(posedge clk_rx or negedge rst_clk_rx_n) begin
      if (!rst_clk_rx_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + (AW + 1)'(1);
         if (do_rd) rd_ptr <= rd_ptr + (AW + 1)'(1);
      end
   end

   // FIFO storage; shift_reg is stable until the next frame's data phase
   always_ff @(posedge clk_rx) begin
      if (do_wr) mem[wr_ptr[AW-1:0]] <= shift_reg;
   end

   assign rx_dout            = rx_fifo_empty ? 8'h00 : mem[rd_ptr[AW-1:0]];
   assign rx_store_qual      = baud_x16_en;
   assign rx_frame_indicator = frame_ind;
   assign rx_bit_indicator   = bit_smp;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx; expected bytes are queued as
// frames are driven and compared as the FIFO is read.
module tb_uart_rx;

   localparam int CLK_HZ = 50_000_000;
   localparam int BAUD   = 650_000;
   localparam int DEPTH  = 16;
   localparam int DIV    = 5;
   localparam int BIT    = 16 * DIV;
`ifdef UART_RX_PARITY_EN
   localparam int NSMP = 10;
`else
   localparam int NSMP = 9;
`endif
   localparam int LAT_LO = 5 + (8 + 16 * NSMP - 1) * DIV;
   localparam int LAT_HI = LAT_LO + DIV - 1;

   logic       clk_rx = 1'b0;
   logic       rst_clk_rx_n = 1'b0;
   logic       rxd_i = 1'b1;
   logic       rd_en = 1'b0;
   logic [7:0] rx_dout;
   logic       rx_fifo_empty;
   logic       frame_err, parity_err, overrun_err;
   logic       rx_store_qual;
   logic [1:0] rx_frame_indicator;
   logic       rx_bit_indicator;

   uart_rx #(.BAUD_RATE(BAUD), .CLOCK_RATE(CLK_HZ), .FIFO_DEPTH(DEPTH)) dut (
      .clk_rx             (clk_rx),
      .rst_clk_rx_n       (rst_clk_rx_n),
      .rxd_i              (rxd_i),
      .rd_en              (rd_en),
      .rx_dout            (rx_dout),
      .rx_fifo_empty      (rx_fifo_empty),
      .frame_err          (frame_err),
      .parity_err         (parity_err),
      .overrun_err        (overrun_err),
      .rx_store_qual      (rx_store_qual),
      .rx_frame_indicator (rx_frame_indicator),
      .rx_bit_indicator   (rx_bit_indicator)
   );

   always #5 clk_rx = ~clk_rx;

   int n_tests = 0;
   int n_fail  = 0;
   int n_ferr  = 0;
   int n_perr  = 0;
   int n_oerr  = 0;
   int n_bits  = 0;
   logic [7:0] exp_q [$];

   // Pulse counters, sampled away from the active edge
   always @(negedge clk_rx) begin
      if (frame_err)        n_ferr <= n_ferr + 1;
      if (parity_err)       n_perr <= n_perr + 1;
      if (overrun_err)      n_oerr <= n_oerr + 1;
      if (rx_bit_indicator) n_bits <= n_bits + 1;
   end

   task automatic check_eq(input string tag, input int obs, input int exp);
      n_tests++;
      if (obs != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", tag, obs, obs, exp, exp);
      end
   endtask

   // Drive one frame starting at a negedge; stop level and length are selectable
   task automatic send_frame(input logic [7:0] d, input logic stop_v, input int stop_len,
                             input logic par_flip);
      rxd_i = 1'b0;
      repeat (BIT) @(negedge clk_rx);
      for (int i = 0; i < 8; i++) begin
         rxd_i = d[i];
         repeat (BIT) @(negedge clk_rx);
      end
`ifdef UART_RX_PARITY_EN
      rxd_i = (^d) ^ par_flip;
      repeat (BIT) @(negedge clk_rx);
`else
      if (par_flip) rxd_i = 1'b1;
`endif
      rxd_i = stop_v;
      repeat (stop_len * BIT) @(negedge clk_rx);
      rxd_i = 1'b1;
      repeat (BIT / 2) @(negedge clk_rx);
   endtask

   // Pop every byte in the FIFO and compare it against the scoreboard
   task automatic drain(input string tag);
      for (int i = 0; i < 2 * DEPTH && !rx_fifo_empty; i++) begin
         if (exp_q.size() == 0) check_eq({tag, " unexpected byte"}, exp_q.size(), 1);
         else                   check_eq(tag, rx_dout, exp_q.pop_front());
         rd_en = 1'b1;
         @(negedge clk_rx);
         rd_en = 1'b0;
      end
      check_eq({tag, " empty"}, rx_fifo_empty, 1);
      check_eq({tag, " queue left"}, exp_q.size(), 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int c, b0, f0, p0, o0, seen;

      repeat (3) @(negedge clk_rx);
      check_eq("rst empty", rx_fifo_empty, 1);
      check_eq("rst dout", rx_dout, 0);
      check_eq("rst frame ind", rx_frame_indicator, 0);
      check_eq("rst pulses", {frame_err, parity_err, overrun_err, rx_bit_indicator, rx_store_qual}, 0);
      rst_clk_rx_n = 1'b1;
      repeat (4) @(negedge clk_rx);

      // Baud tick period
      c = 0;
      while (!rx_store_qual && c < 4 * DIV) begin @(negedge clk_rx); c++; end
      c = 0;
      do begin @(negedge clk_rx); c++; end while (!rx_store_qual && c < 4 * DIV);
      check_eq("tick period", c, DIV);
      repeat (BIT) @(negedge clk_rx);

      // Single byte: latency, data indicator, sample count, pop to empty
      exp_q.push_back(8'hA5);
      b0 = n_bits;
      fork
         send_frame(8'hA5, 1'b1, 1, 1'b0);
         begin
            c = 0;
            while (rx_fifo_empty && c < 12 * BIT) begin @(negedge clk_rx); c++; end
            check_eq("a5 latency in window", int'(c >= LAT_LO && c <= LAT_HI), 1);
         end
         begin
            repeat (3 * BIT) @(negedge clk_rx);
            check_eq("data frame ind", rx_frame_indicator, 2);
         end
      join
      check_eq("a5 bit samples", n_bits - b0, NSMP);
      drain("a5");

      // Short low glitch: back to idle, no write, no errors
      f0 = n_ferr; p0 = n_perr; o0 = n_oerr;
      rxd_i = 1'b0;
      repeat (5 * DIV) @(negedge clk_rx);
      check_eq("glitch start ind", rx_frame_indicator, 1);
      rxd_i = 1'b1;
      repeat (2 * BIT) @(negedge clk_rx);
      check_eq("glitch idle ind", rx_frame_indicator, 0);
      check_eq("glitch empty", rx_fifo_empty, 1);
      check_eq("glitch errors", (n_ferr - f0) + (n_perr - p0) + (n_oerr - o0), 0);

      // Bad stop bit held two bit times, then a good byte
      f0 = n_ferr; p0 = n_perr;
      send_frame(8'h3C, 1'b0, 2, 1'b0);
      check_eq("stop0 frame_err", n_ferr - f0, 1);
      check_eq("stop0 parity_err", n_perr - p0, 0);
      check_eq("stop0 empty", rx_fifo_empty, 1);
      exp_q.push_back(8'h11);
      send_frame(8'h11, 1'b1, 1, 1'b0);
      drain("after stop0");

      // Overrun: 17 bytes into a 16-deep FIFO
      o0 = n_oerr;
      for (int i = 0; i < 17; i++) begin
         send_frame(8'(i), 1'b1, 1, 1'b0);
         if (i < DEPTH) exp_q.push_back(8'(i));
      end
      check_eq("overrun pulse", n_oerr - o0, 1);
      drain("overrun");

      // Read while empty must not move pointers
      rd_en = 1'b1;
      repeat (3) @(negedge clk_rx);
      rd_en = 1'b0;
      check_eq("rd empty stays empty", rx_fifo_empty, 1);

      // Full FIFO: write and read in the same cycle both succeed
      for (int i = 0; i < DEPTH; i++) begin
         send_frame(8'(8'h40 + i), 1'b1, 1, 1'b0);
         exp_q.push_back(8'(8'h40 + i));
      end
      o0 = n_oerr;
      exp_q.push_back(8'h50);
      seen = 0;
      fork
         send_frame(8'h50, 1'b1, 1, 1'b0);
         begin
            for (int k = 0; k < 16 * BIT && seen < NSMP; k++) begin
               @(negedge clk_rx);
               if (rx_bit_indicator) seen++;
            end
            check_eq("simul stop seen", seen, NSMP);
            check_eq("simul head", rx_dout, exp_q.pop_front());
            @(negedge clk_rx);
            rd_en = 1'b1;
            @(negedge clk_rx);
            rd_en = 1'b0;
         end
      join
      check_eq("simul no overrun", n_oerr - o0, 0);
      drain("simul");

`ifdef UART_RX_PARITY_EN
      p0 = n_perr;
      send_frame(8'h01, 1'b1, 1, 1'b1);
      check_eq("parity bad pulse", n_perr - p0, 1);
      check_eq("parity bad empty", rx_fifo_empty, 1);
      exp_q.push_back(8'h01);
      send_frame(8'h01, 1'b1, 1, 1'b0);
      check_eq("parity good no pulse", n_perr - p0, 1);
      drain("parity good");
`else
      check_eq("parity_err never pulses", n_perr, 0);
`endif

      // Reset in the middle of data bit 4 with a byte already stored
      exp_q.push_back(8'h5A);
      send_frame(8'h5A, 1'b1, 1, 1'b0);
      check_eq("pre-reset nonempty", rx_fifo_empty, 0);
      f0 = n_ferr; p0 = n_perr; o0 = n_oerr;
      fork
         send_frame(8'hF0, 1'b1, 1, 1'b0);
         begin
            repeat (5 * BIT + BIT / 2) @(negedge clk_rx);
            rst_clk_rx_n = 1'b0;
            #1;
            check_eq("midrst empty", rx_fifo_empty, 1);
            check_eq("midrst dout", rx_dout, 0);
            check_eq("midrst frame ind", rx_frame_indicator, 0);
            check_eq("midrst pulses", {frame_err, parity_err, overrun_err, rx_bit_indicator, rx_store_qual}, 0);
            repeat (3) @(negedge clk_rx);
            rst_clk_rx_n = 1'b1;
         end
      join
      exp_q.delete();
      repeat (BIT) @(negedge clk_rx);
      check_eq("post-rst no write", rx_fifo_empty, 1);
      check_eq("post-rst no errors", (n_ferr - f0) + (n_perr - p0) + (n_oerr - o0), 0);
      exp_q.push_back(8'hC3);
      send_frame(8'hC3, 1'b1, 1, 1'b0);
      drain("post-rst");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
- REQ-001: The block SHALL have parameter BAUD_RATE, default 57_600, giving the serial bit rate in bps.
- REQ-002: The block SHALL have parameter CLOCK_RATE, default 50_000_000, giving the clk_rx frequency in Hz.
- REQ-003: The block SHALL have parameter FIFO_DEPTH, default 16, giving the receive FIFO depth; it is a power of 2 and at least 2.
- REQ-004: Ports, in order:
  - clk_rx  in  1  single clock
  - rst_clk_rx_n  in  1  reset, asynchronous, active-low
  - rxd_i  in  1  serial input, asynchronous, idle high
  - rd_en  in  1  FIFO pop
  - rx_dout  out  8  FIFO head; first-word-fall-through (FWFT)
  - rx_fifo_empty  out  1  FIFO empty
  - frame_err  out  1  1-cycle pulse
  - parity_err  out  1  1-cycle pulse
  - overrun_err  out  1  1-cycle pulse
  - rx_store_qual  out  1  debug
  - rx_frame_indicator  out  2  debug
  - rx_bit_indicator  out  1  debug

Function
- REQ-005: The baud tick SHALL be a 1-cycle baud_x16_en pulse every DIV clocks, where DIV = round(CLOCK_RATE/(16*BAUD_RATE)); the default DIV is 54.
- REQ-006: rxd_i SHALL pass through a 2-flop synchroniser; all decisions use the synchronised value rxd_s.
- REQ-007: The FSM states and transitions SHALL be:
  - IDLE -> START when rxd_s=0.
  - START: at the 8th tick, go to DATA if rxd_s=0; otherwise return to IDLE as a glitch.
  - DATA: sample every 16th tick; 8 bits, LSB first.
  - DATA -> PARITY if enabled, else DATA -> STOP.
  - PARITY -> STOP after 16 ticks.
  - STOP: sample at the 16th tick, then go to IDLE.
  - STOP -> WAIT_HIGH instead of IDLE if the stop bit is 0.
  - WAIT_HIGH -> IDLE when rxd_s=1.
- REQ-008: The 4-bit oversample counter SHALL clear on every state change and wrap 15->0.
- REQ-009: A valid byte SHALL be written to the FIFO in the cycle after the stop-bit sample; rx_fifo_empty deasserts in the next cycle.
- REQ-010: On a stop bit of 0, the block SHALL pulse frame_err and discard the byte.
- REQ-011: On a parity mismatch, the block SHALL pulse parity_err and discard the byte; if both errors occur, both pulse.
- REQ-012: A write while the FIFO is full and rd_en=0 SHALL drop the byte, pulse overrun_err, and leave the contents unchanged.
- REQ-013: A write and rd_en in the same cycle when full SHALL both succeed.
- REQ-014: rd_en while empty SHALL be ignored, with no pointer change.
- REQ-015: rx_dout SHALL equal the oldest entry while non-empty; its value is don't-care when empty.
- REQ-016: The FIFO pointers SHALL be log2(FIFO_DEPTH)+1 bits wide and wrap naturally; full and empty derive from the MSB compare.
- REQ-017: rx_store_qual SHALL equal baud_x16_en.
- REQ-018: rx_frame_indicator SHALL be 00 in IDLE/WAIT_HIGH, 01 in START, 10 in DATA, and 11 in PARITY/STOP.
- REQ-019: rx_bit_indicator SHALL pulse in each cycle a data, parity or stop bit is sampled.

Reset
- REQ-020: Assertion of rst_clk_rx_n SHALL take effect immediately, even mid-frame, and reset the block as follows:
  - FSM to IDLE.
  - Counters, synchroniser and FIFO pointers cleared, with the synchroniser set to 1.
  - rx_fifo_empty=1, rx_dout=0, and all pulses and debug outputs 0.
- REQ-021: After deassertion, the block SHALL need a full new start bit; no partial frame is delivered.

Configuration
- REQ-022: Macro UART_RX_PARITY_EN SHALL control parity, as follows:
  - Defined: the frame is 8E1; the PARITY state exists; an even parity check drives parity_err.
  - Undefined: the frame is 8N1; the PARITY state is absent; parity_err is tied 0.

Verification
- REQ-023: Serial 0xA5 (8N1, default parameters) -> rx_fifo_empty falls about 9.5 bit times after the start edge; rx_dout=0xA5; rd_en -> rx_fifo_empty=1.
- REQ-024: rxd_i low for 5 ticks then high -> returns to IDLE; no write; no error pulses.
- REQ-025: 0x3C with stop bit 0 for 2 bit times -> one frame_err pulse; FIFO empty; the next 0x11 is received correctly.
- REQ-026: 17 bytes 0x00..0x10 with no reads -> the 17th gives an overrun_err pulse; reads return 0x00..0x0F, then empty.
- REQ-027: With UART_RX_PARITY_EN: 0x01 with parity bit 0 -> parity_err pulse, no write; 0x01 with parity bit 1 -> stored.
- REQ-028: Reset asserted during bit 4 of a frame -> outputs take reset values at once; the remaining bits produce no write.
